sram_port_arb: RTL



---
 rtl/sram_port_arb_pkg.sv | 23 ++
 rtl/sram_port_arb_rr.sv | 56 +++++
 rtl/sram_port_arb.sv | 101 ++++++++++
 3 files changed

// File: rtl/sram_port_arb_pkg.sv
// rtl/sram_port_arb_pkg.sv - shared constants, request record and round-robin pick for sram_port_arb
package sram_port_arb_pkg;
    localparam int ADDR_W       = 14;
    localparam int DATA_W       = 128;
    localparam int BE_W         = DATA_W / 8;
    localparam int NUM_REQ      = 2;
    localparam int MAX_LOCK_DEF = 8;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } req_t;

    // Lone requester wins outright; on contention the pointer decides.
    function automatic logic rr_pick(input logic [NUM_REQ-1:0] valid, input logic ptr);
        if (valid == 2'b11) begin
            return ptr;
        end
        return valid[1];
    endfunction
endpackage

// File: rtl/sram_port_arb_rr.sv
// rtl/sram_port_arb_rr.sv - 2-way round-robin pointer with bounded lock hold
module sram_port_arb_rr
    import sram_port_arb_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [NUM_REQ-1:0] lock_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               grant_vld_o
);
    localparam int CNT_W = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK - 1);

    logic             ptr_q, ptr_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] base;
    logic             gidx;

    always_comb begin
        gidx        = rr_pick(valid_i, ptr_q);
        grant_vld_o = (|valid_i) & ~rst;
        grant_o     = grant_vld_o ? (NUM_REQ'(1) << gidx) : '0;
        // Hold count only carries over while the same requester keeps winning.
        base        = (gidx == last_q) ? cnt_q : '0;
        ptr_d       = ptr_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        if (grant_vld_o) begin
            last_d = gidx;
            if (lock_i[gidx] && (base < CNT_MAX)) begin
                ptr_d = gidx;
                cnt_d = base + 1'b1;
            end else begin
                ptr_d = ~gidx;
                // Uncontended locked streams saturate instead of restarting the hold.
                cnt_d = (lock_i[gidx] && !valid_i[~gidx]) ? base : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q  <= 1'b0;
            last_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            last_q <= last_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/sram_port_arb.sv
// rtl/sram_port_arb.sv - CPU/loader arbiter in front of the single-port SRAM
// Optional perf counters enabled by SRAM_PORT_ARB_PERF_EN.
module sram_port_arb
    import sram_port_arb_pkg::*;
#(
    parameter int MAX_LOCK = MAX_LOCK_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [2*BE_W-1:0]     req_be,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_W-1:0]     sram_addr,
    output logic [DATA_W-1:0]     sram_wdata,
    output logic [BE_W-1:0]       sram_be,
`ifdef SRAM_PORT_ARB_PERF_EN
    output logic [31:0]           perf_grant0,
    output logic [31:0]           perf_grant1,
    output logic [31:0]           perf_conflict,
`endif
    input  logic [DATA_W-1:0]     sram_rdata
);
    req_t               reqs [NUM_REQ];
    req_t               sel;
    logic [NUM_REQ-1:0] grant;
    logic               grant_vld;
    logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;

    sram_port_arb_rr #(.MAX_LOCK(MAX_LOCK)) u_rr (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (req_valid),
        .lock_i     (req_lock),
        .grant_o    (grant),
        .grant_vld_o(grant_vld)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].we    = req_we[i];
            reqs[i].addr  = req_addr[i*ADDR_W +: ADDR_W];
            reqs[i].wdata = req_wdata[i*DATA_W +: DATA_W];
            reqs[i].be    = req_be[i*BE_W +: BE_W];
        end
        sel        = reqs[grant[1]];
        req_ready  = grant;
        sram_en    = grant_vld;
        sram_we    = grant_vld & sel.we;
        sram_addr  = sel.addr;
        sram_wdata = sel.wdata;
        sram_be    = grant_vld ? sel.be : '0;
        // The grant vector doubles as the response tag for the next cycle.
        rsp_vld_d  = (grant_vld && !sel.we) ? grant : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_vld_q <= '0;
        end else begin
            rsp_vld_q <= rsp_vld_d;
        end
    end

    // Masked by rst so a response in flight when reset hits is never seen.
    assign rsp_valid = rsp_vld_q & {NUM_REQ{~rst}};
    assign rsp_rdata = sram_rdata;

`ifdef SRAM_PORT_ARB_PERF_EN
    logic [31:0] perf_g0_q, perf_g1_q, perf_cf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_g0_q <= '0;
            perf_g1_q <= '0;
            perf_cf_q <= '0;
        end else begin
            if (grant[0]) begin
                perf_g0_q <= perf_g0_q + 32'd1;
            end
            if (grant[1]) begin
                perf_g1_q <= perf_g1_q + 32'd1;
            end
            if (&req_valid) begin
                perf_cf_q <= perf_cf_q + 32'd1;
            end
        end
    end

    assign perf_grant0   = perf_g0_q;
    assign perf_grant1   = perf_g1_q;
    assign perf_conflict = perf_cf_q;
`endif
endmodule
